// File: rtl/ex_mult_hilo.sv
// Iterative shift-add multiplier with the HI/LO register pair.
// Handles MULT/MULTU, MTHI/MTLO; MFHI/MFLO read o_hi/o_lo directly.
module ex_mult_hilo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_signed,
   input  logic [WIDTH-1:0] i_srcLeft,
   input  logic [WIDTH-1:0] i_srcRight,
   input  logic             i_writeHi,
   input  logic             i_writeLo,
   input  logic             i_flush,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo,
   output logic             o_busy,
   output logic             o_done
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   logic [1:0]         state_q,  state_d;
   logic [WIDTH-1:0]   hi_q,     hi_d;
   logic [WIDTH-1:0]   lo_q,     lo_d;
   logic               busy_q,   busy_d;
   logic               done_q,   done_d;
   logic [2*WIDTH-1:0] acc_q,    acc_d;
   logic [WIDTH-1:0]   mcand_q,  mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      cnt_q,    cnt_d;
   logic               neg_q,    neg_d;

   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH:0]   step;
   logic [2*WIDTH-1:0] acc_neg;

   // Magnitude of the most negative value wraps to itself, which is correct unsigned.
   assign a_mag   = (i_signed && i_srcLeft[WIDTH-1])  ? (~i_srcLeft + 1'b1)  : i_srcLeft;
   assign b_mag   = (i_signed && i_srcRight[WIDTH-1]) ? (~i_srcRight + 1'b1) : i_srcRight;
   assign sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
   assign step    = {sum, acc_q[WIDTH-1:0]};
   assign acc_neg = ~acc_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               mcand_d  = a_mag;
               mplier_d = b_mag;
               neg_d    = i_signed & (i_srcLeft[WIDTH-1] ^ i_srcRight[WIDTH-1]);
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = ST_BUSY;
            end else begin
               if (i_writeHi) hi_d = i_srcLeft;
               if (i_writeLo) lo_d = i_srcLeft;
            end
         end
         ST_BUSY: begin
            if (i_flush) begin
               state_d = ST_IDLE;
            end else begin
               acc_d    = step[2*WIDTH:1];
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            state_d = ST_IDLE;
            if (!i_flush) begin
               {hi_d, lo_d} = neg_q ? acc_neg : acc_q;
               done_d       = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
      end
   end

   assign o_hi   = hi_q;
   assign o_lo   = lo_q;
   assign o_busy = busy_q;
   assign o_done = done_q;

endmodule
